// File: rtl/time_slot_generator_if.sv
// Config/strobe bundle between the global config registers, the slot generator and its consumers.
interface time_slot_generator_if #(
  parameter int SLOT_W = 10
);
  logic              i_qbv_or_qch;
  logic [10:0]       iv_time_slot_length;
  logic [10:0]       iv_schedule_period;
  logic              i_slot_restart;
  logic [SLOT_W-1:0] ov_time_slot;
  logic              o_time_slot_switch;
  logic              o_period_start;
  logic              o_cfg_err;

  modport master (
    output i_qbv_or_qch,
    output iv_time_slot_length,
    output iv_schedule_period,
    output i_slot_restart,
    input  ov_time_slot,
    input  o_time_slot_switch,
    input  o_period_start,
    input  o_cfg_err
  );

  modport slave (
    input  i_qbv_or_qch,
    input  iv_time_slot_length,
    input  iv_schedule_period,
    input  i_slot_restart,
    output ov_time_slot,
    output o_time_slot_switch,
    output o_period_start,
    output o_cfg_err
  );
endinterface

// File: rtl/time_slot_generator.sv
// Free-running time-slot index generator with slot-switch / period-start strobes.
// Config is shadowed and only applied at period wraps, on restart, or while holding on bad config.
module time_slot_generator #(
  parameter int UNIT_CYCLES = 125,
  parameter int SLOT_W      = 10
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  time_slot_generator_if.slave s_if
);

  localparam int UW = $clog2(UNIT_CYCLES);

  typedef enum logic {ST_RUN, ST_HOLD} state_t;

  state_t            r_state,  w_state_nxt;
  logic [UW-1:0]     r_unit_cnt, w_unit_nxt;
  logic [10:0]       r_len_cnt,  w_len_nxt;
  logic [SLOT_W-1:0] r_slot,     w_slot_nxt;
  logic              r_switch,   w_switch_nxt;
  logic              r_pstart,   w_pstart_nxt;
  logic              r_err,      w_err_nxt;
  logic              r_mode;
  logic [10:0]       r_len;
  logic [10:0]       r_period;

  logic              w_in_period_ok;
  logic              w_in_valid;
  logic [10:0]       w_period_eff;
  logic [10:0]       w_period_m1;
  logic              w_unit_wrap;
  logic              w_slot_end;
  logic              w_last_slot;
  logic              w_reload;

  // Validity of the live inputs, which is what the shadow will hold after a reload.
  assign w_in_period_ok = s_if.i_qbv_or_qch ||
                          ((s_if.iv_schedule_period != 11'd0) &&
                           (32'(s_if.iv_schedule_period) <= (32'd1 << SLOT_W)));
  assign w_in_valid     = (s_if.iv_time_slot_length != 11'd0) && w_in_period_ok;

  assign w_period_eff = r_mode ? 11'd2 : r_period;
  assign w_period_m1  = w_period_eff - 11'd1;
  assign w_unit_wrap  = (r_unit_cnt == UW'(UNIT_CYCLES - 1));
  assign w_slot_end   = (r_state == ST_RUN) && w_unit_wrap && (r_len_cnt == r_len - 11'd1);
  assign w_last_slot  = (32'(r_slot) == 32'(w_period_m1));

  // Restart, HOLD and period wrap all realign to slot 0 from a freshly reloaded config;
  // restart wins over a coincident slot end so only one strobe pair is produced.
  assign w_reload = s_if.i_slot_restart || (r_state == ST_HOLD) || (w_slot_end && w_last_slot);

  always_comb begin
    w_state_nxt  = r_state;
    w_unit_nxt   = r_unit_cnt;
    w_len_nxt    = r_len_cnt;
    w_slot_nxt   = r_slot;
    w_switch_nxt = 1'b0;
    w_pstart_nxt = 1'b0;
    w_err_nxt    = r_err;

    if (w_reload) begin
      w_unit_nxt = '0;
      w_len_nxt  = '0;
      w_slot_nxt = '0;
      if (w_in_valid) begin
        w_state_nxt  = ST_RUN;
        w_err_nxt    = 1'b0;
        w_switch_nxt = 1'b1;
        w_pstart_nxt = 1'b1;
      end else begin
        w_state_nxt = ST_HOLD;
        w_err_nxt   = 1'b1;
      end
    end else if (w_slot_end) begin
      w_unit_nxt   = '0;
      w_len_nxt    = '0;
      w_slot_nxt   = r_slot + SLOT_W'(1);
      w_switch_nxt = 1'b1;
    end else if (w_unit_wrap) begin
      w_unit_nxt = '0;
      w_len_nxt  = r_len_cnt + 11'd1;
    end else begin
      w_unit_nxt = r_unit_cnt + UW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_RUN;
      r_unit_cnt <= '0;
      r_len_cnt  <= '0;
      r_slot     <= '0;
      r_switch   <= 1'b0;
      r_pstart   <= 1'b0;
      r_err      <= 1'b0;
      r_mode     <= 1'b1;
      r_len      <= 11'd4;
      r_period   <= 11'd2;
    end else begin
      r_state    <= w_state_nxt;
      r_unit_cnt <= w_unit_nxt;
      r_len_cnt  <= w_len_nxt;
      r_slot     <= w_slot_nxt;
      r_switch   <= w_switch_nxt;
      r_pstart   <= w_pstart_nxt;
      r_err      <= w_err_nxt;
      if (w_reload) begin
        r_mode   <= s_if.i_qbv_or_qch;
        r_len    <= s_if.iv_time_slot_length;
        r_period <= s_if.iv_schedule_period;
      end
    end
  end

  assign s_if.ov_time_slot       = r_slot;
  assign s_if.o_time_slot_switch = r_switch;
  assign s_if.o_period_start     = r_pstart;
  assign s_if.o_cfg_err          = r_err;

endmodule

// File: tb/tb_time_slot_generator.sv
// Directed bench for time_slot_generator with UNIT_CYCLES=4; status = {slot, switch, period_start, cfg_err}.
module tb_time_slot_generator;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  time_slot_generator_if #(.SLOT_W(10)) ifc ();

  time_slot_generator #(.UNIT_CYCLES(4), .SLOT_W(10)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .s_if  (ifc.slave)
  );

  logic [12:0] status;
  assign status = {ifc.ov_time_slot, ifc.o_time_slot_switch, ifc.o_period_start, ifc.o_cfg_err};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic qch, input logic [10:0] len, input logic [10:0] period);
    ifc.i_qbv_or_qch        = qch;
    ifc.iv_time_slot_length = len;
    ifc.iv_schedule_period  = period;
  endtask

  task automatic pulse_restart();
    ifc.i_slot_restart = 1'b1;
    tick();
    ifc.i_slot_restart = 1'b0;
  endtask

  // Returns the number of edges until a switch strobe is seen, or -1 if none within limit.
  task automatic wait_switch(input int limit, output int n);
    bit found;
    found = 1'b0;
    n = -1;
    for (int i = 1; i <= limit && !found; i++) begin
      tick();
      if (ifc.o_time_slot_switch) begin
        n = i;
        found = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    tests_run++; if (status !== 13'd0) begin tests_failed++; $display("[TB] FAIL reset_status got %h want %h", status, 13'd0); end
    rst = 1'b0;
  endtask

  task automatic test_qch_default();
    int n;
    wait_switch(40, n);
    tests_run++; if (n !== 16) begin tests_failed++; $display("[TB] FAIL qch_first_len got %0d want 16", n); end
    tests_run++; if (status !== {10'd1, 3'b100}) begin tests_failed++; $display("[TB] FAIL qch_s1 got %h want %h", status, {10'd1, 3'b100}); end
    wait_switch(40, n);
    tests_run++; if (n !== 16) begin tests_failed++; $display("[TB] FAIL qch_len_s0 got %0d want 16", n); end
    tests_run++; if (status !== {10'd0, 3'b110}) begin tests_failed++; $display("[TB] FAIL qch_s0 got %h want %h", status, {10'd0, 3'b110}); end
    wait_switch(40, n);
    tests_run++; if (n !== 16 || status !== {10'd1, 3'b100}) begin tests_failed++; $display("[TB] FAIL qch_s1b n=%0d status=%h want 16 %h", n, status, {10'd1, 3'b100}); end
    wait_switch(40, n);
    tests_run++; if (n !== 16 || status !== {10'd0, 3'b110}) begin tests_failed++; $display("[TB] FAIL qch_s0b n=%0d status=%h want 16 %h", n, status, {10'd0, 3'b110}); end
  endtask

  task automatic test_qbv_period3();
    int n;
    applyStimulus(1'b0, 11'd2, 11'd3);
    pulse_restart();
    tests_run++; if (status !== {10'd0, 3'b110}) begin tests_failed++; $display("[TB] FAIL qbv_restart got %h want %h", status, {10'd0, 3'b110}); end
    wait_switch(30, n);
    tests_run++; if (n !== 8 || status !== {10'd1, 3'b100}) begin tests_failed++; $display("[TB] FAIL qbv_s1 n=%0d status=%h want 8 %h", n, status, {10'd1, 3'b100}); end
    wait_switch(30, n);
    tests_run++; if (n !== 8 || status !== {10'd2, 3'b100}) begin tests_failed++; $display("[TB] FAIL qbv_s2 n=%0d status=%h want 8 %h", n, status, {10'd2, 3'b100}); end
    wait_switch(30, n);
    tests_run++; if (n !== 8 || status !== {10'd0, 3'b110}) begin tests_failed++; $display("[TB] FAIL qbv_wrap n=%0d status=%h want 8 %h", n, status, {10'd0, 3'b110}); end
  endtask

  task automatic test_mid_period_change();
    int n;
    wait_switch(30, n);
    tests_run++; if (n !== 8 || status !== {10'd1, 3'b100}) begin tests_failed++; $display("[TB] FAIL mid_s1 n=%0d status=%h want 8 %h", n, status, {10'd1, 3'b100}); end
    applyStimulus(1'b0, 11'd5, 11'd3);
    wait_switch(30, n);
    tests_run++; if (n !== 8 || status !== {10'd2, 3'b100}) begin tests_failed++; $display("[TB] FAIL mid_s2_old_len n=%0d status=%h want 8 %h", n, status, {10'd2, 3'b100}); end
    wait_switch(30, n);
    tests_run++; if (n !== 8 || status !== {10'd0, 3'b110}) begin tests_failed++; $display("[TB] FAIL mid_wrap n=%0d status=%h want 8 %h", n, status, {10'd0, 3'b110}); end
    wait_switch(40, n);
    tests_run++; if (n !== 20 || status !== {10'd1, 3'b100}) begin tests_failed++; $display("[TB] FAIL mid_new_len n=%0d status=%h want 20 %h", n, status, {10'd1, 3'b100}); end
  endtask

  task automatic test_cfg_hold();
    int n;
    int sw_seen;
    applyStimulus(1'b0, 11'd5, 11'd0);
    wait_switch(40, n);
    tests_run++; if (n !== 20 || status !== {10'd2, 3'b100}) begin tests_failed++; $display("[TB] FAIL hold_pre_s2 n=%0d status=%h want 20 %h", n, status, {10'd2, 3'b100}); end
    n = -1;
    sw_seen = 0;
    for (int i = 1; i <= 40 && n < 0; i++) begin
      tick();
      if (ifc.o_time_slot_switch) sw_seen++;
      if (ifc.o_cfg_err) n = i;
    end
    tests_run++; if (n !== 20) begin tests_failed++; $display("[TB] FAIL hold_entry_time got %0d want 20", n); end
    tests_run++; if (sw_seen !== 0 || status !== {10'd0, 3'b001}) begin tests_failed++; $display("[TB] FAIL hold_entry sw=%0d status=%h want 0 %h", sw_seen, status, {10'd0, 3'b001}); end
    repeat (3) tick();
    tests_run++; if (status !== {10'd0, 3'b001}) begin tests_failed++; $display("[TB] FAIL hold_stay got %h want %h", status, {10'd0, 3'b001}); end
    applyStimulus(1'b0, 11'd2, 11'd3);
    tick();
    tests_run++; if (status !== {10'd0, 3'b110}) begin tests_failed++; $display("[TB] FAIL hold_exit got %h want %h", status, {10'd0, 3'b110}); end
    wait_switch(30, n);
    tests_run++; if (n !== 8 || status !== {10'd1, 3'b100}) begin tests_failed++; $display("[TB] FAIL hold_first_sw n=%0d status=%h want 8 %h", n, status, {10'd1, 3'b100}); end
  endtask

  task automatic test_restart();
    int n;
    wait_switch(30, n);
    tests_run++; if (n !== 8 || status !== {10'd2, 3'b100}) begin tests_failed++; $display("[TB] FAIL rst_pre_s2 n=%0d status=%h want 8 %h", n, status, {10'd2, 3'b100}); end
    repeat (3) tick();
    pulse_restart();
    tests_run++; if (status !== {10'd0, 3'b110}) begin tests_failed++; $display("[TB] FAIL restart_mid got %h want %h", status, {10'd0, 3'b110}); end
    wait_switch(30, n);
    tests_run++; if (n !== 8 || status !== {10'd1, 3'b100}) begin tests_failed++; $display("[TB] FAIL restart_next n=%0d status=%h want 8 %h", n, status, {10'd1, 3'b100}); end
  endtask

  task automatic test_restart_at_slot_end();
    int n;
    repeat (7) tick();
    pulse_restart();
    tests_run++; if (status !== {10'd0, 3'b110}) begin tests_failed++; $display("[TB] FAIL restart_coinc got %h want %h", status, {10'd0, 3'b110}); end
    tick();
    tests_run++; if (status !== {10'd0, 3'b000}) begin tests_failed++; $display("[TB] FAIL restart_single got %h want %h", status, {10'd0, 3'b000}); end
    wait_switch(30, n);
    tests_run++; if (n !== 7 || status !== {10'd1, 3'b100}) begin tests_failed++; $display("[TB] FAIL restart_coinc_next n=%0d status=%h want 7 %h", n, status, {10'd1, 3'b100}); end
  endtask

  task automatic test_reset_mid();
    int n;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    tests_run++; if (status !== 13'd0) begin tests_failed++; $display("[TB] FAIL midrst_status got %h want %h", status, 13'd0); end
    rst = 1'b0;
    wait_switch(40, n);
    tests_run++; if (n !== 16 || status !== {10'd1, 3'b100}) begin tests_failed++; $display("[TB] FAIL midrst_s1 n=%0d status=%h want 16 %h", n, status, {10'd1, 3'b100}); end
    wait_switch(40, n);
    tests_run++; if (n !== 16 || status !== {10'd0, 3'b110}) begin tests_failed++; $display("[TB] FAIL midrst_wrap n=%0d status=%h want 16 %h", n, status, {10'd0, 3'b110}); end
    wait_switch(40, n);
    tests_run++; if (n !== 8 || status !== {10'd1, 3'b100}) begin tests_failed++; $display("[TB] FAIL midrst_newcfg n=%0d status=%h want 8 %h", n, status, {10'd1, 3'b100}); end
  endtask

  task automatic test_cfg_boundaries();
    int n;
    applyStimulus(1'b1, 11'd1, 11'd0);
    pulse_restart();
    tests_run++; if (status !== {10'd0, 3'b110}) begin tests_failed++; $display("[TB] FAIL qch_p0_valid got %h want %h", status, {10'd0, 3'b110}); end
    wait_switch(20, n);
    tests_run++; if (n !== 4 || status !== {10'd1, 3'b100}) begin tests_failed++; $display("[TB] FAIL len1_s1 n=%0d status=%h want 4 %h", n, status, {10'd1, 3'b100}); end
    wait_switch(20, n);
    tests_run++; if (n !== 4 || status !== {10'd0, 3'b110}) begin tests_failed++; $display("[TB] FAIL len1_s0 n=%0d status=%h want 4 %h", n, status, {10'd0, 3'b110}); end
    applyStimulus(1'b1, 11'd0, 11'd0);
    pulse_restart();
    tests_run++; if (status !== {10'd0, 3'b001}) begin tests_failed++; $display("[TB] FAIL len0_hold got %h want %h", status, {10'd0, 3'b001}); end
    applyStimulus(1'b1, 11'd1, 11'd0);
    tick();
    tests_run++; if (status !== {10'd0, 3'b110}) begin tests_failed++; $display("[TB] FAIL len0_exit got %h want %h", status, {10'd0, 3'b110}); end
    applyStimulus(1'b0, 11'd2, 11'd1025);
    pulse_restart();
    tests_run++; if (status !== {10'd0, 3'b001}) begin tests_failed++; $display("[TB] FAIL p1025_hold got %h want %h", status, {10'd0, 3'b001}); end
    applyStimulus(1'b0, 11'd2, 11'd1024);
    tick();
    tests_run++; if (status !== {10'd0, 3'b110}) begin tests_failed++; $display("[TB] FAIL p1024_exit got %h want %h", status, {10'd0, 3'b110}); end
    wait_switch(30, n);
    tests_run++; if (n !== 8 || status !== {10'd1, 3'b100}) begin tests_failed++; $display("[TB] FAIL p1024_s1 n=%0d status=%h want 8 %h", n, status, {10'd1, 3'b100}); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    clk = 1'b0;
    rst = 1'b1;
    ifc.i_slot_restart = 1'b0;
    applyStimulus(1'b1, 11'd4, 11'd2);
    repeat (2) tick();

    test_reset();
    test_qch_default();
    test_qbv_period3();
    test_mid_period_change();
    test_cfg_hold();
    test_restart();
    test_restart_at_slot_end();
    test_reset_mid();
    test_cfg_boundaries();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
